instruction_queue: RTL and testbench
====================================

# instruction_queue

Decoupling FIFO between instruction fetch and the issue/dispatch path. It buffers fetched instruction words with their PCs and issues them in program order, one per cycle, to the reorder buffer and decoder as a registered `get_instruction` pulse with `isq_ins_out`/`isq_pc_out`. On `roll_back` it discards all queued and in-flight work.

## Interface
- `ISQ_SIZE`, default 16: queue depth; power of two, ≥4.
- `ADDR_W`, default 4: log2(`ISQ_SIZE`).

- `clk_in`  in  1  system clock; all state updates on posedge.
- `rst_in`  in  1  asynchronous, active-low reset. Low clears all state immediately, independent of the clock.
- `rdy_in`  in  1  pause; when low, every register holds.
- `roll_back`  in  1  mispredict flush from commit.
- `ifetch_valid`  in  1  fetch presents an instruction this cycle.
- `ifetch_ins`  in  32  instruction word.
- `ifetch_pc`  in  32  PC of `ifetch_ins`.
- `isq_full`  out  1  combinational; `count == ISQ_SIZE`.
- `isq_empty`  out  1  combinational; `count == 0`.
- `isq_count`  out  ADDR_W+1  current occupancy.
- `issue_stall`  in  1  downstream (ROB/RS/LSB) cannot take 2 more entries.
- `get_instruction`  out  1  registered; one instruction is issued this cycle.
- `isq_ins_out`  out  32  registered instruction word.
- `isq_pc_out`  out  32  registered PC.

## Operation
- Storage: `ISQ_SIZE` × {ins[31:0], pc[31:0]}. Head pointer, tail pointer (ADDR_W bits, natural wrap) and an explicit count (ADDR_W+1 bits).
- Reset (`rst_in`=0, async): head=tail=count=0, `get_instruction`=0, `isq_ins_out`=0, `isq_pc_out`=0. Array contents are don't-care.
- Priority per edge: reset > `roll_back` > `!rdy_in` (hold everything) > normal.
- `roll_back` (with `rdy_in` high or low): head=tail=count=0, `get_instruction`<=0. A push in the same cycle is discarded. `roll_back` overrides a low `rdy_in`.
- Push: if `ifetch_valid && !isq_full`, write {ins, pc} at tail, then tail++. If `ifetch_valid && isq_full`, the word is dropped and there is no state change. Fetch must not do this.
- Pop: if `!isq_empty && !issue_stall`, register mem[head] onto the outputs, set `get_instruction`<=1, then head++. Otherwise `get_instruction`<=0. The data outputs hold their last value.
- Simultaneous push and pop: both occur. count unchanged.
- `isq_full` and `isq_empty` are evaluated from the pre-edge count.
  - When full, a push in the same cycle as a pop is still rejected.
  - When empty, a push is not bypassed to the output. The earliest issue is at the next edge.
- Count update: count + push − pop. It never exceeds `ISQ_SIZE` and never underflows.
- Pause: while `rdy_in` is low, `get_instruction` and the data outputs hold. A pulse issued before the pause therefore remains visible until the consumer samples it at an edge with `rdy_in` high.

## Timing
- Fetch-to-issue latency, empty queue, no stall: push at edge N, `get_instruction`=1 after edge N+1. That is 1 cycle of storage plus a registered output.
- Throughput: one push and one pop per cycle sustained.
- One issued instruction is always in flight, because the consumer sees the registered pulse one cycle later. `issue_stall` must therefore assert when the downstream has room for fewer than 2 entries.
- `get_instruction` is a single-cycle pulse per instruction. Back-to-back pulses are allowed.
- Wrap-around: pointers roll from `ISQ_SIZE`−1 to 0 with no bubble.

## Test plan
- Reset: drive `rst_in` low mid-cycle with the queue holding 5 entries → all outputs and `isq_count` go to 0 before the next clock edge. After release, the first push is issued 2 edges later.
- Fill and drain, with `issue_stall`=1:
  - Push 16 words with PC 0x0,0x4..0x3C → `isq_full`=1 and `isq_count`=16. A 17th push is dropped.
  - Drop `issue_stall` → 16 consecutive `get_instruction` pulses, with PCs 0x0..0x3C in order.
- Steady state with wrap: push and pop simultaneously for 40 cycles, PCs incrementing by 4 → count stays constant, output PCs are strictly sequential across pointer wrap, and there are no bubbles.
- Flush: with 7 entries queued and a push plus a pending issue in the same cycle, assert `roll_back` → next cycle count=0, `get_instruction`=0, and the pushed word never appears.
- Pause: assert `get_instruction` with PC 0x100, then hold `rdy_in` low for 3 cycles while toggling `ifetch_valid` → outputs stay at 0x100 with pulse high and count is unchanged. After `rdy_in` returns, the next PC is 0x104.
- Stall boundary: toggle `issue_stall` every cycle with 4 entries queued → pulses occur only on edges where the stall was low, and no entry is duplicated or skipped.

Source files
------------

// File: rtl/instruction_queue.sv
// instruction_queue: FIFO between instruction fetch and issue/dispatch.
// Buffers {ins, pc} pairs and issues them in program order, one per cycle,
// as a registered get_instruction pulse with registered word and PC.
// roll_back discards all queued and in-flight work; rdy_in low freezes state.

module instruction_queue #(
  parameter int unsigned ISQ_SIZE = 16,
  parameter int unsigned ADDR_W   = 4
) (
  input  logic              clk_in,
  input  logic              rst_in,
  input  logic              rdy_in,
  input  logic              roll_back,

  input  logic              ifetch_valid,
  input  logic [31:0]       ifetch_ins,
  input  logic [31:0]       ifetch_pc,

  output logic              isq_full,
  output logic              isq_empty,
  output logic [ADDR_W:0]   isq_count,

  input  logic              issue_stall,
  output logic              get_instruction,
  output logic [31:0]       isq_ins_out,
  output logic [31:0]       isq_pc_out
);

  localparam int unsigned CNT_W  = ADDR_W + 1;
  localparam int unsigned DATA_W = 32;

  // One queue slot: instruction word and its PC.
  typedef struct packed {
    logic [DATA_W-1:0] ins;
    logic [DATA_W-1:0] pc;
  } isq_entry_t;

  isq_entry_t        mem [ISQ_SIZE];
  logic [ADDR_W-1:0] head_q;
  logic [ADDR_W-1:0] tail_q;
  logic [CNT_W-1:0]  count_q;

  logic              push_c;
  logic              pop_c;
  logic              advance_c;
  isq_entry_t        wr_entry_c;
  isq_entry_t        rd_entry_c;

  // Status flags come from the pre-edge count, so a full queue rejects a
  // push even when a pop happens in the same cycle.
  assign isq_full  = (count_q == CNT_W'(ISQ_SIZE));
  assign isq_empty = (count_q == '0);
  assign isq_count = count_q;

  // Push/pop qualifiers; an empty queue never bypasses fetch to the output.
  always_comb begin
    push_c         = 1'b0;
    pop_c          = 1'b0;
    advance_c      = rdy_in && !roll_back;
    wr_entry_c.ins = ifetch_ins;
    wr_entry_c.pc  = ifetch_pc;
    rd_entry_c     = mem[head_q];
    if (ifetch_valid && !isq_full) begin
      push_c = 1'b1;
    end
    if (!isq_empty && !issue_stall) begin
      pop_c = 1'b1;
    end
  end

  // Storage array write; contents need no reset since head/tail/count gate use.
  always_ff @(posedge clk_in) begin
    if (advance_c && push_c) begin
      mem[tail_q] <= wr_entry_c;
    end
  end

  // Pointers and occupancy: flush clears, pause holds, otherwise count+push-pop.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else if (roll_back) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else if (rdy_in) begin
      if (push_c) begin
        tail_q <= tail_q + ADDR_W'(1);
      end
      if (pop_c) begin
        head_q <= head_q + ADDR_W'(1);
      end
      count_q <= count_q + CNT_W'(push_c) - CNT_W'(pop_c);
    end
  end

  // Registered issue interface; data holds when nothing issues or on flush.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      get_instruction <= 1'b0;
      isq_ins_out     <= '0;
      isq_pc_out      <= '0;
    end else if (roll_back) begin
      get_instruction <= 1'b0;
    end else if (rdy_in) begin
      get_instruction <= pop_c;
      if (pop_c) begin
        isq_ins_out <= rd_entry_c.ins;
        isq_pc_out  <= rd_entry_c.pc;
      end
    end
  end

endmodule

// File: tb/tb_instruction_queue.sv
// Directed bench for instruction_queue: a vector table for basic push/pop,
// pause and flush behaviour, then hand-written multi-cycle sequences.

module tb_instruction_queue;

  logic        clk_in;
  logic        rst_in;
  logic        rdy_in;
  logic        roll_back;
  logic        ifetch_valid;
  logic [31:0] ifetch_ins;
  logic [31:0] ifetch_pc;
  logic        isq_full;
  logic        isq_empty;
  logic [4:0]  isq_count;
  logic        issue_stall;
  logic        get_instruction;
  logic [31:0] isq_ins_out;
  logic [31:0] isq_pc_out;

  int n_chk;
  int n_fail;

  instruction_queue #(.ISQ_SIZE(16), .ADDR_W(4)) dut (
    .clk_in          (clk_in),
    .rst_in          (rst_in),
    .rdy_in          (rdy_in),
    .roll_back       (roll_back),
    .ifetch_valid    (ifetch_valid),
    .ifetch_ins      (ifetch_ins),
    .ifetch_pc       (ifetch_pc),
    .isq_full        (isq_full),
    .isq_empty       (isq_empty),
    .isq_count       (isq_count),
    .issue_stall     (issue_stall),
    .get_instruction (get_instruction),
    .isq_ins_out     (isq_ins_out),
    .isq_pc_out      (isq_pc_out)
  );

  initial clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  typedef struct {
    logic        rdy;
    logic        rb;
    logic        vld;
    logic        stall;
    logic [31:0] pc;
    logic        e_get;
    logic [31:0] e_pc;
    logic [31:0] e_ins;
    logic [4:0]  e_cnt;
    logic        e_full;
    logic        e_empty;
  } vec_t;

  vec_t tbl [11];

  function automatic logic [31:0] insw(input logic [31:0] pc);
    return pc ^ 32'hC0DE_0000;
  endfunction

  function automatic vec_t mk(input logic rdy, input logic rb, input logic vld,
                              input logic stall, input logic [31:0] pc,
                              input logic e_get, input logic [31:0] e_pc,
                              input logic [31:0] e_ins, input logic [4:0] e_cnt,
                              input logic e_empty);
    vec_t v;
    v.rdy = rdy; v.rb = rb; v.vld = vld; v.stall = stall; v.pc = pc;
    v.e_get = e_get; v.e_pc = e_pc; v.e_ins = e_ins; v.e_cnt = e_cnt;
    v.e_full = 1'b0; v.e_empty = e_empty;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic rdy, input logic rb, input logic vld,
                       input logic [31:0] pc, input logic stall);
    rdy_in       = rdy;
    roll_back    = rb;
    ifetch_valid = vld;
    ifetch_pc    = pc;
    ifetch_ins   = insw(pc);
    issue_stall  = stall;
  endtask

  task automatic step();
    @(posedge clk_in);
    #1;
  endtask

  task automatic chk_issue(input string name, input logic e_get, input logic [31:0] e_pc,
                           input logic [4:0] e_cnt);
    chk({name, "_get"}, 32'(get_instruction), 32'(e_get));
    chk({name, "_pc"},  isq_pc_out, e_pc);
    chk({name, "_ins"}, isq_ins_out, insw(e_pc));
    chk({name, "_cnt"}, 32'(isq_count), 32'(e_cnt));
  endtask

  initial begin
    n_chk  = 0;
    n_fail = 0;
    rst_in = 1'b0;
    drive(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);

    // Vector table: inputs for one edge, then expected post-edge outputs.
    tbl[0]  = mk(1, 0, 1, 0, 32'h10, 0, 32'h0,  32'h0,        5'd1, 0);
    tbl[1]  = mk(1, 0, 1, 0, 32'h14, 1, 32'h10, insw(32'h10), 5'd1, 0);
    tbl[2]  = mk(1, 0, 0, 0, 32'h0,  1, 32'h14, insw(32'h14), 5'd0, 1);
    tbl[3]  = mk(1, 0, 0, 0, 32'h0,  0, 32'h14, insw(32'h14), 5'd0, 1);
    tbl[4]  = mk(1, 0, 1, 1, 32'h18, 0, 32'h14, insw(32'h14), 5'd1, 0);
    tbl[5]  = mk(1, 0, 1, 1, 32'h1C, 0, 32'h14, insw(32'h14), 5'd2, 0);
    tbl[6]  = mk(1, 0, 0, 0, 32'h0,  1, 32'h18, insw(32'h18), 5'd1, 0);
    tbl[7]  = mk(0, 0, 1, 0, 32'h20, 1, 32'h18, insw(32'h18), 5'd1, 0);
    tbl[8]  = mk(1, 0, 1, 0, 32'h20, 1, 32'h1C, insw(32'h1C), 5'd1, 0);
    tbl[9]  = mk(0, 1, 1, 0, 32'h24, 0, 32'h1C, insw(32'h1C), 5'd0, 1);
    tbl[10] = mk(1, 0, 0, 0, 32'h0,  0, 32'h1C, insw(32'h1C), 5'd0, 1);

    // Reset state
    repeat (2) @(posedge clk_in);
    #1;
    chk("rst_get",   32'(get_instruction), 32'h0);
    chk("rst_pc",    isq_pc_out, 32'h0);
    chk("rst_ins",   isq_ins_out, 32'h0);
    chk("rst_cnt",   32'(isq_count), 32'h0);
    chk("rst_empty", 32'(isq_empty), 32'h1);
    chk("rst_full",  32'(isq_full), 32'h0);
    rst_in = 1'b1;

    // Table-driven vectors
    for (int i = 0; i < 11; i++) begin
      drive(tbl[i].rdy, tbl[i].rb, tbl[i].vld, tbl[i].pc, tbl[i].stall);
      step();
      chk($sformatf("vec%0d_get", i),   32'(get_instruction), 32'(tbl[i].e_get));
      chk($sformatf("vec%0d_pc", i),    isq_pc_out, tbl[i].e_pc);
      chk($sformatf("vec%0d_ins", i),   isq_ins_out, tbl[i].e_ins);
      chk($sformatf("vec%0d_cnt", i),   32'(isq_count), 32'(tbl[i].e_cnt));
      chk($sformatf("vec%0d_full", i),  32'(isq_full), 32'(tbl[i].e_full));
      chk($sformatf("vec%0d_empty", i), 32'(isq_empty), 32'(tbl[i].e_empty));
    end

    // Asynchronous reset mid-cycle with 5 entries queued and a live pulse
    for (int i = 0; i < 6; i++) begin
      drive(1'b1, 1'b0, 1'b1, 32'h600 + 32'(4 * i), 1'b1);
      step();
    end
    drive(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
    step();
    chk_issue("prerst", 1'b1, 32'h600, 5'd5);
    drive(1'b1, 1'b0, 1'b0, 32'h0, 1'b1);
    #3;
    rst_in = 1'b0;
    #1;
    chk("arst_get",   32'(get_instruction), 32'h0);
    chk("arst_pc",    isq_pc_out, 32'h0);
    chk("arst_ins",   isq_ins_out, 32'h0);
    chk("arst_cnt",   32'(isq_count), 32'h0);
    chk("arst_empty", 32'(isq_empty), 32'h1);
    #1;
    rst_in = 1'b1;
    drive(1'b1, 1'b0, 1'b1, 32'h200, 1'b0);
    step();
    chk("post_rst_e1_get", 32'(get_instruction), 32'h0);
    chk("post_rst_e1_cnt", 32'(isq_count), 32'h1);
    drive(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
    step();
    chk_issue("post_rst_e2", 1'b1, 32'h200, 5'd0);

    // Fill to 16 under stall, 17th push dropped, then drain in order
    for (int i = 0; i < 16; i++) begin
      drive(1'b1, 1'b0, 1'b1, 32'(4 * i), 1'b1);
      step();
    end
    chk("fill_full", 32'(isq_full), 32'h1);
    chk("fill_cnt",  32'(isq_count), 32'd16);
    drive(1'b1, 1'b0, 1'b1, 32'h40, 1'b1);
    step();
    chk("ovf_full", 32'(isq_full), 32'h1);
    chk("ovf_cnt",  32'(isq_count), 32'd16);
    chk("ovf_get",  32'(get_instruction), 32'h0);
    // Full queue: push alongside the first pop is still rejected
    drive(1'b1, 1'b0, 1'b1, 32'h44, 1'b0);
    step();
    chk_issue("drain0", 1'b1, 32'h0, 5'd15);
    drive(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
    for (int i = 1; i < 16; i++) begin
      step();
      chk_issue($sformatf("drain%0d", i), 1'b1, 32'(4 * i), 5'(15 - i));
    end
    step();
    chk("drain_end_get",   32'(get_instruction), 32'h0);
    chk("drain_end_empty", 32'(isq_empty), 32'h1);

    // Steady state: simultaneous push/pop for 40 cycles across pointer wrap
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 1'b0, 1'b1, 32'h1000 + 32'(4 * i), 1'b1);
      step();
    end
    for (int i = 0; i < 40; i++) begin
      drive(1'b1, 1'b0, 1'b1, 32'h100C + 32'(4 * i), 1'b0);
      step();
      chk_issue($sformatf("steady%0d", i), 1'b1, 32'h1000 + 32'(4 * i), 5'd3);
    end
    drive(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      step();
      chk_issue($sformatf("steady_tail%0d", i), 1'b1, 32'h10A0 + 32'(4 * i), 5'(2 - i));
    end
    step();
    chk("steady_end_get", 32'(get_instruction), 32'h0);

    // Flush with 7 queued, a push and a pending issue in the same cycle
    for (int i = 0; i < 7; i++) begin
      drive(1'b1, 1'b0, 1'b1, 32'h2000 + 32'(4 * i), 1'b1);
      step();
    end
    chk("preflush_cnt", 32'(isq_count), 32'd7);
    drive(1'b1, 1'b1, 1'b1, 32'h3000, 1'b0);
    step();
    chk("flush_cnt",   32'(isq_count), 32'h0);
    chk("flush_get",   32'(get_instruction), 32'h0);
    chk("flush_empty", 32'(isq_empty), 32'h1);
    drive(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
    for (int i = 0; i < 2; i++) begin
      step();
      chk($sformatf("postflush%0d_get", i), 32'(get_instruction), 32'h0);
      chk($sformatf("postflush%0d_cnt", i), 32'(isq_count), 32'h0);
    end

    // Pause: issued 0x100 stays visible while rdy_in is low
    drive(1'b1, 1'b0, 1'b1, 32'h100, 1'b1);
    step();
    drive(1'b1, 1'b0, 1'b1, 32'h104, 1'b1);
    step();
    drive(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
    step();
    chk_issue("pause_pre", 1'b1, 32'h100, 5'd1);
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 1'b0, (i % 2) == 0, 32'h500, 1'b0);
      step();
      chk_issue($sformatf("pause%0d", i), 1'b1, 32'h100, 5'd1);
    end
    drive(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
    step();
    chk_issue("pause_resume", 1'b1, 32'h104, 5'd0);
    step();
    chk("pause_end_get", 32'(get_instruction), 32'h0);

    // Stall boundary: toggle issue_stall each cycle with 4 entries queued
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 1'b0, 1'b1, 32'h4000 + 32'(4 * i), 1'b1);
      step();
    end
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, 1'b0, 1'b0, 32'h0, (i % 2) == 1);
      step();
      if ((i % 2) == 0) begin
        chk_issue($sformatf("tog%0d", i), 1'b1, 32'h4000 + 32'(4 * (i / 2)), 5'(3 - i / 2));
      end else begin
        chk_issue($sformatf("tog%0d", i), 1'b0, 32'h4000 + 32'(4 * (i / 2)), 5'(3 - i / 2));
      end
    end
    chk("tog_end_empty", 32'(isq_empty), 32'h1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
